// File: rtl/time_entry_pkg.sv
// Shared types and constants for the time_entry key-to-centisecond front end.
// Digit index 4 is minutes, index 0 is hundredths.
package time_entry_pkg;

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  typedef logic [3:0] bcd_t;

  localparam int NUM_DIGITS = 5;

  localparam logic [2:0] DIG_M   = 3'd4;
  localparam logic [2:0] DIG_S10 = 3'd3;
  localparam logic [2:0] DIG_S1  = 3'd2;
  localparam logic [2:0] DIG_C10 = 3'd1;
  localparam logic [2:0] DIG_C1  = 3'd0;

  // Tens-of-seconds is the only digit that rolls over at 5.
  function automatic bcd_t wrap_limit(input logic [2:0] idx);
    return (idx == DIG_S10) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [16:0] place_weight(input logic [2:0] idx);
    logic [16:0] w;
    case (idx)
      DIG_M:   w = 17'd6000;
      DIG_S10: w = 17'd1000;
      DIG_S1:  w = 17'd100;
      DIG_C10: w = 17'd10;
      default: w = 17'd1;
    endcase
    return w;
  endfunction

  // Largest reachable value is 9:59.99 = 59999, so 17 bits never overflow.
  function automatic logic [16:0] to_centis(input logic [19:0] d);
    logic [16:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sum = sum + 17'(d[i*4 +: 4]) * place_weight(3'(i));
    end
    return sum;
  endfunction

endpackage

// File: rtl/time_entry_button_conditioner.sv
// Raw active-low key -> 2-flop synchronizer -> debouncer -> one-cycle press event.
// A key already held when reset releases stays silent until it is seen released.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pressed,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          armed;
  logic [1:0]    fill;
  logic [CW-1:0] cnt;
  logic          settle;

  assign settle  = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign press   = settle && !sync2 && armed;
  assign pressed = !stable && armed;

  // fill marks when sync2 holds a real sample rather than its reset value,
  // so arming needs a genuinely released key.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      fill   <= '0;
      armed  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && sync2 && stable) begin
        armed <= 1'b1;
      end
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (settle) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/time_entry.sv
// Pushbutton time editor: edits M:SS.cc as BCD and commits it as binary centiseconds.
// Optional auto-repeat on the increment key is enabled by TIME_ENTRY_AUTO_REPEAT_EN.
module time_entry
  import time_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_btn,
  input  logic        next_btn,
  input  logic        load_btn,
  output logic [19:0] digits,
  output logic [4:0]  digit_sel,
  output logic        editing,
  output logic [15:0] time_out,
  output logic        load_pulse
);

  state_t      state;
  logic [2:0]  cursor;
  logic [19:0] dig_r;
  logic [2:0]  held;
  logic        inc_press;
  logic        next_evt;
  logic        load_evt;
  logic        inc_evt;
  bcd_t        cur_digit;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .reset(reset), .btn(inc_btn), .pressed(held[0]), .press(inc_press)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .reset(reset), .btn(next_btn), .pressed(held[1]), .press(next_evt)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk(clk), .reset(reset), .btn(load_btn), .pressed(held[2]), .press(load_evt)
  );

`ifdef TIME_ENTRY_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_fire;
  logic          unused_held;

  assign rpt_fire    = (state == EDIT) && held[0] && (rpt_cnt == RW'(REPEAT_CYCLES - 1));
  assign inc_evt     = inc_press | rpt_fire;
  assign unused_held = ^held[2:1];

  // Counts hold time since the last inc event; any cursor move or exit restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt <= '0;
    end else if ((state != EDIT) || !held[0] || next_evt || load_evt || inc_press || rpt_fire) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign inc_evt    = inc_press;
  assign unused_cfg = ^{held, REPEAT_CYCLES};
`endif

  assign cur_digit = dig_r[{cursor, 2'b00} +: 4];
  assign digits    = dig_r;
  assign editing   = (state == EDIT);
  assign digit_sel = editing ? (5'd1 << cursor) : 5'd0;

  // In EDIT a load beats a cursor move, which beats an increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cursor     <= DIG_M;
      dig_r      <= '0;
      time_out   <= '0;
      load_pulse <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (next_evt) begin
            state  <= EDIT;
            cursor <= DIG_M;
          end
        end
        EDIT: begin
          if (load_evt) begin
            state <= COMMIT;
          end else if (next_evt) begin
            cursor <= (cursor == DIG_C1) ? DIG_M : cursor - 3'd1;
          end else if (inc_evt) begin
            dig_r[{cursor, 2'b00} +: 4] <= (cur_digit == wrap_limit(cursor)) ? 4'd0 : cur_digit + 4'd1;
          end
        end
        COMMIT: begin
          time_out   <= 16'(to_centis(dig_r));
          load_pulse <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
